// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 responder backed by an internal word-addressed SRAM.
// Read and write channels are independent FSMs with one outstanding
// transaction each. The array is dual-ported, so a read and a write can
// proceed in the same cycle; a read of a word written in that cycle returns
// the old value.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   aw_* / w_* / b_*           write address, data and response channels
//   ar_* / r_*                 read address and data channels
//   dbg_r_state, dbg_w_state   current read / write FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid, once raised by this slave, stays up and its payload stays
// stable until the matching ready is seen.
//
// Optional build macro AXI_SLV_BACKPRESSURE_EN: an LFSR throttles ar_ready,
// aw_ready, w_ready and the rise of r_valid, to exercise master stalls.
module axi_sram_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      aw_valid,
    output logic                      aw_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] aw_addr,
    input  logic [AXI_ID_WIDTH-1:0]   aw_id,
    input  logic [7:0]                aw_len,
    input  logic [2:0]                aw_size,
    input  logic [1:0]                aw_burst,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [AXI_DATA_WIDTH-1:0] w_data,
    input  logic [AXI_STRB_WIDTH-1:0] w_strb,
    input  logic                      w_last,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic [AXI_ID_WIDTH-1:0]   b_id,
    output logic [1:0]                b_resp,
    input  logic                      ar_valid,
    output logic                      ar_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] ar_addr,
    input  logic [AXI_ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]                ar_len,
    input  logic [2:0]                ar_size,
    input  logic [1:0]                ar_burst,
    output logic                      r_valid,
    input  logic                      r_ready,
    output logic [AXI_DATA_WIDTH-1:0] r_data,
    output logic [AXI_ID_WIDTH-1:0]   r_id,
    output logic [1:0]                r_resp,
    output logic                      r_last,
    output logic [1:0]                dbg_r_state,
    output logic [1:0]                dbg_w_state
);
    localparam int LOG2_STRB = $clog2(AXI_STRB_WIDTH);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN = AXI_ADDR_WIDTH'(MEM_DEPTH * AXI_STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Address of the beat following addr. WRAP keeps the low bits inside a
    // (len+1)<<size window and leaves the window base untouched.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [2:0] size,
        input logic [7:0] len, input logic [1:0] burst);
        logic [AXI_ADDR_WIDTH-1:0] incr, win_mask;
        incr     = AXI_ADDR_WIDTH'(1) << size;
        win_mask = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
        case (burst)
            2'd0:    next_addr = addr;
            2'd2:    next_addr = (addr & ~win_mask) | ((addr + incr) & win_mask);
            default: next_addr = addr + incr;
        endcase
    endfunction

    // Per-beat error: out of the array window, beat wider than the bus,
    // illegal WRAP length or reserved burst type.
    function automatic logic beat_err(
        input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [2:0] size,
        input logic [7:0] len, input logic [1:0] burst);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        beat_err = (addr < BASE_ADDR) || (off >= SPAN) || (size > 3'(LOG2_STRB)) ||
                   (burst == 2'd3) ||
                   ((burst == 2'd2) && !((len == 8'd1) || (len == 8'd3) ||
                                         (len == 8'd7) || (len == 8'd15)));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        word_idx = off[LOG2_STRB +: IDX_W];
    endfunction

    // Handshake gates: constant 1 unless the backpressure LFSR is built in.
    logic ar_gate, aw_gate, wr_gate, rv_gate;
`ifdef AXI_SLV_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lfsr_q <= 16'hACE1;
        else          lfsr_q <= lfsr_d;
    end
    assign ar_gate = lfsr_q[0];
    assign aw_gate = lfsr_q[1];
    assign wr_gate = lfsr_q[2];
    assign rv_gate = lfsr_q[3];
`else
    assign ar_gate = 1'b1;
    assign aw_gate = 1'b1;
    assign wr_gate = 1'b1;
    assign rv_gate = 1'b1;
`endif

    // ---------------- read channel ----------------
    r_state_e                  r_state_q, r_state_d;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]                r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]                r_size_q, r_size_d;
    logic [1:0]                r_burst_q, r_burst_d, r_resp_q, r_resp_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                      r_last_q, r_last_d, r_valid_q, r_valid_d;
    logic [AXI_ADDR_WIDTH-1:0] rd_addr;
    logic                      rd_err;
    logic [AXI_DATA_WIDTH-1:0] rd_data;

    // Beat to be loaded into the output register: the first beat straight
    // from ar_* while idle, otherwise the successor of the beat on the bus.
    always_comb begin
        if (r_state_q == R_IDLE) begin
            rd_addr = ar_addr;
            rd_err  = beat_err(ar_addr, ar_size, ar_len, ar_burst);
        end else begin
            rd_addr = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
            rd_err  = beat_err(rd_addr, r_size_q, r_len_q, r_burst_q);
        end
        rd_data = rd_err ? '0 : mem[word_idx(rd_addr)];
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        r_valid_d = r_valid_q;
        ar_ready  = (r_state_q == R_IDLE) && ar_gate;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid && ar_ready) begin
                    r_state_d = R_DATA;
                    r_addr_d  = ar_addr;
                    r_len_d   = ar_len;
                    r_size_d  = ar_size;
                    r_burst_d = ar_burst;
                    r_id_d    = ar_id;
                    r_cnt_d   = 8'd0;
                    r_data_d  = rd_data;
                    r_resp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                    r_last_d  = (ar_len == 8'd0);
                    r_valid_d = rv_gate;
                end
            end
            R_DATA: begin
                if (!r_valid_q) begin
                    r_valid_d = rv_gate;
                end else if (r_ready) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                        r_valid_d = 1'b0;
                    end else begin
                        r_addr_d  = rd_addr;
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_data_d  = rd_data;
                        r_resp_d  = rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_last_d  = ((r_cnt_q + 8'd1) == r_len_q);
                        r_valid_d = rv_gate;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
            r_valid_q <= r_valid_d;
        end
    end

    assign r_valid     = r_valid_q;
    assign r_data      = r_data_q;
    assign r_id        = r_id_q;
    assign r_resp      = r_resp_q;
    assign r_last      = r_last_q;
    assign dbg_r_state = r_state_q;

    // ---------------- write channel ----------------
    w_state_e                  w_state_q, w_state_d;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]                w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]                w_size_q, w_size_d;
    logic [1:0]                w_burst_q, w_burst_d, b_resp_q, b_resp_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    // w_over: len+1 beats already taken; further beats are accepted only.
    logic                      w_err_q, w_err_d, w_over_q, w_over_d, b_valid_q, b_valid_d;
    logic                      wr_err, mem_we;
    logic [IDX_W-1:0]          mem_idx;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_id_d    = w_id_q;
        w_err_d   = w_err_q;
        w_over_d  = w_over_q;
        b_resp_d  = b_resp_q;
        b_valid_d = b_valid_q;
        mem_we    = 1'b0;
        mem_idx   = word_idx(w_addr_q);
        wr_err    = beat_err(w_addr_q, w_size_q, w_len_q, w_burst_q);
        aw_ready  = (w_state_q == W_IDLE) && aw_gate;
        w_ready   = (w_state_q == W_DATA) && wr_gate;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid && aw_ready) begin
                    w_state_d = W_DATA;
                    w_addr_d  = aw_addr;
                    w_len_d   = aw_len;
                    w_size_d  = aw_size;
                    w_burst_d = aw_burst;
                    w_id_d    = aw_id;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_over_d  = 1'b0;
                end
            end
            W_DATA: begin
                if (w_valid && w_ready) begin
                    if (!w_over_q) begin
                        mem_we   = !wr_err;
                        w_err_d  = w_err_q || wr_err;
                        w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
                        if (w_cnt_q == w_len_q) w_over_d = 1'b1;
                        else                    w_cnt_d  = w_cnt_q + 8'd1;
                    end
                    if (w_last) begin
                        w_state_d = W_RESP;
                        b_valid_d = 1'b1;
                        // The last beat is good only if it is beat number len.
                        b_resp_d  = (w_over_q || (w_cnt_q != w_len_q) || w_err_q || wr_err)
                                    ? RESP_SLVERR : RESP_OKAY;
                    end
                end
            end
            W_RESP: begin
                if (b_ready) begin
                    w_state_d = W_IDLE;
                    b_valid_d = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_err_q   <= 1'b0;
            w_over_q  <= 1'b0;
            b_resp_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_err_q   <= w_err_d;
            w_over_q  <= w_over_d;
            b_resp_q  <= b_resp_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int i = 0; i < AXI_STRB_WIDTH; i++) begin
                if (w_strb[i]) mem[mem_idx][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    assign b_valid     = b_valid_q;
    assign b_resp      = b_resp_q;
    assign b_id        = w_id_q;
    assign dbg_w_state = w_state_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_8000;

  logic        i_clk, i_rst_n;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [31:0] aw_addr, ar_addr;
  logic [3:0]  aw_id, ar_id, b_id, r_id;
  logic [7:0]  aw_len, ar_len, w_strb;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp, dbg_r_state, dbg_w_state;
  logic [63:0] w_data, r_data;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

  axi_sram_slave dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id),
    .r_resp(r_resp), .r_last(r_last),
    .dbg_r_state(dbg_r_state), .dbg_w_state(dbg_w_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mdl [int];

  function automatic logic [31:0] beat_addr(input logic [31:0] a0, input int size,
                                            input int len, input int burst, input int i);
    logic [31:0] bytes, win, wbase;
    bytes = 32'd1 << size;
    win   = 32'(len + 1) * bytes;
    wbase = a0 - (a0 % win);
    case (burst)
      0: beat_addr = a0;
      2: beat_addr = wbase + ((a0 - wbase + 32'(i) * bytes) % win);
      default: beat_addr = a0 + 32'(i) * bytes;
    endcase
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input int size, input int len, input int burst);
    bit in_rng;
    in_rng = (a >= BASE) && ((a - BASE) < SPAN);
    beat_bad = !in_rng || (size > 3) ||
               (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic int widx(input logic [31:0] a);
    widx = int'((a - BASE) >> 3);
  endfunction

  // ---------------- scoreboard ----------------
  logic [70:0] r_exp_q[$];   // {id, resp, last, data}
  logic [5:0]  b_exp_q[$];   // {id, resp}
  logic [70:0] r_got_q[$];
  logic [5:0]  b_got_q[$];

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (r_valid) begin
        if (r_exp_q.size() == 0) chk("r_unexpected", {r_id, r_resp, r_last, r_data}, 96'hx);
        else chk("r_beat", {r_id, r_resp, r_last, r_data}, r_exp_q[0]);
        if (r_ready) begin
          r_got_q.push_back({r_id, r_resp, r_last, r_data});
          if (r_exp_q.size() > 0) void'(r_exp_q.pop_front());
        end
      end
      if (b_valid) begin
        if (b_exp_q.size() == 0) chk("b_unexpected", {b_id, b_resp}, 96'hx);
        else chk("b_resp", {b_id, b_resp}, b_exp_q[0]);
        if (b_ready) begin
          b_got_q.push_back({b_id, b_resp});
          if (b_exp_q.size() > 0) void'(b_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic [63:0] wd [256];
  logic [7:0]  ws [256];

  task automatic do_read(input logic [31:0] a, input logic [3:0] id, input int len,
                         input int size, input int burst, input int stall);
    int got, cyc, t;
    bit first;
    logic [31:0] ba;
    bit bad;
    for (int i = 0; i <= len; i++) begin
      ba  = beat_addr(a, size, len, burst, i);
      bad = beat_bad(ba, size, len, burst);
      r_exp_q.push_back({id, bad ? 2'b10 : 2'b00, (i == len), bad ? 64'd0 : mdl[widx(ba)]});
    end
    ar_addr = a; ar_id = id; ar_len = 8'(len); ar_size = 3'(size); ar_burst = 2'(burst);
    ar_valid = 1'b1;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!ar_ready && t < 200);
    if (!ar_ready) chk("ar_timeout", 0, 1);
    @(posedge i_clk); #1;
    ar_valid = 1'b0;
    got = 0; cyc = 0; first = 1'b1;
    while (got < len + 1 && cyc < 2000) begin
      r_ready = (stall > 0) ? (cyc >= stall) : ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (first) chk("r_latency", r_valid, 1);
      first = 1'b0;
      if (r_valid && r_ready) got++;
      cyc++;
      @(posedge i_clk); #1;
    end
    r_ready = 1'b0;
    if (got < len + 1) begin
      chk("r_timeout", got, len + 1);
      r_exp_q.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input int len,
                          input int size, input int burst, input int nb);
    logic [31:0] ba;
    logic [63:0] w;
    bit bad;
    int t;
    bit done;
    bad = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i <= len) begin
        ba = beat_addr(a, size, len, burst, i);
        if (beat_bad(ba, size, len, burst)) bad = 1'b1;
        else begin
          w = mdl.exists(widx(ba)) ? mdl[widx(ba)] : 64'hx;
          for (int b = 0; b < 8; b++) if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
          mdl[widx(ba)] = w;
        end
      end
    end
    if (nb - 1 != len) bad = 1'b1;
    b_exp_q.push_back({id, bad ? 2'b10 : 2'b00});
    aw_addr = a; aw_id = id; aw_len = 8'(len); aw_size = 3'(size); aw_burst = 2'(burst);
    aw_valid = 1'b1;
    t = 0;
    do begin @(negedge i_clk); t++; end while (!aw_ready && t < 200);
    if (!aw_ready) chk("aw_timeout", 0, 1);
    @(posedge i_clk); #1;
    aw_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if ($urandom_range(0, 3) == 0) begin w_valid = 1'b0; @(posedge i_clk); #1; end
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == nb - 1);
      t = 0;
      do begin @(negedge i_clk); t++; end while (!w_ready && t < 200);
      if (!w_ready) chk("w_timeout", i, nb);
      @(posedge i_clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    done = 1'b0; t = 0;
    while (!done && t < 200) begin
      b_ready = ($urandom_range(0, 2) != 0);
      @(negedge i_clk);
      if (b_valid && b_ready) done = 1'b1;
      t++;
      @(posedge i_clk); #1;
    end
    b_ready = 1'b0;
    if (!done) begin chk("b_timeout", 0, 1); b_exp_q.delete(); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, size, burst, nb, sel;
    logic [31:0] a;
    i_rst_n = 1'b0;
    aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
    ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
    r_ready = 0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    w_valid = 1'b1; w_last = 1'b1;   // early W data must not be taken
    @(negedge i_clk);
    chk("rst_ar_ready", ar_ready, 1);
    chk("rst_aw_ready", aw_ready, 1);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_valids", {r_valid, b_valid}, 0);
    chk("rst_r_fields", {r_id, r_resp, r_last, r_data}, 0);
    chk("rst_b_fields", {b_id, b_resp}, 0);
    @(posedge i_clk); #1;
    w_valid = 1'b0; w_last = 1'b0;

    // fill words 0..63 and the top word so every later read is defined
    for (int i = 0; i < 64; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    do_write(BASE, 4'd3, 63, 3, 1, 64);
    wd[0] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF;
    do_write(BASE + SPAN - 8, 4'd4, 0, 3, 1, 1);

    // single write then read
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    b_got_q.delete();
    do_write(32'h8000_0008, 4'd1, 0, 3, 1, 1);
    chk("sw_bresp", b_got_q[0], {4'd1, 2'b00});
    r_got_q.delete();
    do_read(32'h8000_0008, 4'd1, 0, 3, 1, 0);
    chk("sw_rdata", r_got_q[0], {4'd1, 2'b00, 1'b1, 64'h1122_3344_5566_7788});

    // strobed write
    wd[0] = 64'd0; ws[0] = 8'hFF;
    do_write(BASE, 4'd2, 0, 3, 1, 1);
    wd[0] = 64'hAABB_CCDD_EEFF_0011; ws[0] = 8'h0C;
    do_write(BASE, 4'd2, 0, 3, 1, 1);
    r_got_q.delete();
    do_read(BASE, 4'd2, 0, 3, 1, 0);
    chk("strb_rdata", r_got_q[0], {4'd2, 2'b00, 1'b1, 64'h0000_0000_EEFF_0000});

    // INCR burst with a 3-cycle stall on beat 0
    wd[0] = 64'hA; wd[1] = 64'hB; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(32'h8000_0100, 4'd6, 1, 3, 1, 2);
    r_got_q.delete();
    do_read(32'h8000_0100, 4'd5, 1, 3, 1, 3);
    chk("incr_beat0", r_got_q[0], {4'd5, 2'b00, 1'b0, 64'hA});
    chk("incr_beat1", r_got_q[1], {4'd5, 2'b00, 1'b1, 64'hB});

    // out of range just below the base
    r_got_q.delete();
    do_read(32'h7FFF_FFF8, 4'd7, 0, 3, 1, 0);
    chk("oor_read", r_got_q[0], {4'd7, 2'b10, 1'b1, 64'd0});
    wd[0] = 64'h5555_5555_5555_5555; ws[0] = 8'hFF;
    b_got_q.delete();
    do_write(32'h7FFF_FFF8, 4'd7, 0, 3, 1, 1);
    chk("oor_bresp", b_got_q[0], {4'd7, 2'b10});
    r_got_q.delete();
    do_read(BASE + SPAN - 8, 4'd7, 0, 3, 1, 0);
    chk("oor_top_word", r_got_q[0], {4'd7, 2'b00, 1'b1, 64'hDEAD_BEEF_0BAD_F00D});

    // WRAP len=3 size=3 from offset 0x18
    chk("wrap_a0", beat_addr(32'h8000_0018, 3, 3, 2, 0) - BASE, 32'h18);
    chk("wrap_a1", beat_addr(32'h8000_0018, 3, 3, 2, 1) - BASE, 32'h00);
    chk("wrap_a2", beat_addr(32'h8000_0018, 3, 3, 2, 2) - BASE, 32'h08);
    chk("wrap_a3", beat_addr(32'h8000_0018, 3, 3, 2, 3) - BASE, 32'h10);
    for (int i = 0; i < 4; i++) begin wd[i] = 64'h10 + 64'(i); ws[i] = 8'hFF; end
    do_write(32'h8000_0018, 4'd8, 3, 3, 2, 4);
    r_got_q.delete();
    do_read(BASE, 4'd9, 3, 3, 1, 0);
    chk("wrap_w0", r_got_q[0][63:0], 64'h11);
    chk("wrap_w3", r_got_q[3][63:0], 64'h10);
    do_read(32'h8000_0018, 4'd9, 3, 3, 2, 0);

    // early w_last
    wd[0] = 64'h77; ws[0] = 8'hFF;
    b_got_q.delete();
    do_write(32'h8000_0200, 4'd10, 1, 3, 1, 1);
    chk("early_last", b_got_q[0], {4'd10, 2'b10});

    // reset in the middle of a read burst
    for (int i = 0; i <= 7; i++)
      r_exp_q.push_back({4'd11, 2'b00, (i == 7), mdl[i]});
    ar_addr = BASE; ar_id = 4'd11; ar_len = 8'd7; ar_size = 3'd3; ar_burst = 2'd1;
    ar_valid = 1'b1; r_ready = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk); #1 ar_valid = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk); #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", r_valid, 0);
    chk("mid_rst_arready", ar_ready, 1);
    r_exp_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      burst = $urandom_range(0, 2);
      if (burst == 2) begin
        sel = $urandom_range(0, 4);
        len = (sel == 4) ? 2 : ((1 << (sel + 1)) - 1);
      end else len = $urandom_range(0, 15);
      size = ($urandom_range(0, 15) == 0) ? 4 : $urandom_range(0, 3);
      sel = $urandom_range(0, 9);
      if (sel == 0) a = BASE - 32'(8 * $urandom_range(1, 4));
      else if (sel == 1) a = BASE + SPAN - 8 + 32'(8 * $urandom_range(0, 3));
      else a = BASE + 32'(8 * $urandom_range(0, 31) + $urandom_range(0, 7));
      if (size <= 3) a = a & ~((32'd1 << size) - 1);
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, 4'($urandom), len, size, burst, 0);
      end else begin
        sel = $urandom_range(0, 7);
        nb = (sel == 0 && len > 0) ? len : ((sel == 1) ? len + 2 : len + 1);
        for (int i = 0; i < nb; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(a, 4'($urandom), len, size, burst, nb);
      end
    end

    repeat (3) @(posedge i_clk);
    chk("r_exp_drained", r_exp_q.size(), 0);
    chk("b_exp_drained", b_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
